// File: rtl/spi_slave_regs.sv
// rtl/spi_slave_regs.sv - SPI slave (modes 0-3) with an 8x8 register file; cmd byte then data byte.
// Define SPI_SLV_AUTOINC_EN to keep streaming data bytes to successive addresses within one frame.
`timescale 1ns/1ps
module spi_slave_regs (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       cs_bar,
  input  logic       MOSI,
  output logic       MISO,
  output logic       miso_oe,
  input  logic [1:0] MODE,
  input  logic [2:0] host_addr,
  output logic [7:0] host_rdata,
  output logic       frame_done,
  output logic       frame_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] TAIL = 2'd3;

  logic       sclk_s1, sclk_s2, sclk_d;
  logic       cs_s1, cs_s2, cs_d;
  logic       mosi_s1, mosi_s2;
  logic [1:0] settle;
  logic       locked;

  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [1:0] mode_q;
  logic [7:0] rx_sh;
  logic [7:0] tx_sh;
  logic       rw;
  logic [2:0] addr;
  logic       byte_seen;
  logic       miso_q;
  logic [7:0] regs [8];

  logic       sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic       sample_edge, shift_edge;
  logic       cs_fall, cs_rise;
  logic [7:0] rx_byte;
  logic [2:0] addr_nxt;

  assign sclk_rise   = sclk_s2 & ~sclk_d;
  assign sclk_fall   = ~sclk_s2 & sclk_d;
  assign lead_edge   = mode_q[1] ? sclk_fall : sclk_rise;
  assign trail_edge  = mode_q[1] ? sclk_rise : sclk_fall;
  assign sample_edge = mode_q[0] ? trail_edge : lead_edge;
  assign shift_edge  = mode_q[0] ? lead_edge : trail_edge;
  assign cs_fall     = cs_d & ~cs_s2;
  assign cs_rise     = ~cs_d & cs_s2;
  assign rx_byte     = {rx_sh[6:0], mosi_s2};
  assign addr_nxt    = addr + 3'd1;

  assign miso_oe    = ~cs_s2 & ~locked;
  assign MISO       = miso_q & miso_oe;
  assign host_rdata = regs[host_addr];

  // Synchronizers reset to the idle bus levels; the lockout only clears once a
  // post-reset sample of cs_bar has reached cs_s2 and shows it high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_d    <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      settle  <= 2'd0;
      locked  <= 1'b1;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      cs_s1   <= cs_bar;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      mosi_s1 <= MOSI;
      mosi_s2 <= mosi_s1;
      if (settle != 2'd3) settle <= settle + 2'd1;
      if (settle == 2'd3 && cs_s2) locked <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      mode_q     <= 2'd0;
      rx_sh      <= 8'h00;
      tx_sh      <= 8'h00;
      rw         <= 1'b0;
      addr       <= 3'd0;
      byte_seen  <= 1'b0;
      miso_q     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (state == IDLE) begin
        miso_q <= 1'b0;
        if (cs_fall && !locked) begin
          state     <= CMD;
          mode_q    <= MODE;
          bit_cnt   <= 3'd0;
          byte_seen <= 1'b0;
        end
      end else if (cs_rise) begin
        state     <= IDLE;
        miso_q    <= 1'b0;
        // A deselect is clean only after a whole data byte has completed.
        frame_err <= (state == CMD) ||
                     (state == DATA && (bit_cnt != 3'd0 || !byte_seen));
      end else begin
        case (state)
          CMD: begin
            if (shift_edge) miso_q <= 1'b0;
            if (sample_edge) begin
              rx_sh   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw    <= rx_byte[7];
                addr  <= rx_byte[2:0];
                tx_sh <= rx_byte[7] ? regs[rx_byte[2:0]] : 8'h00;
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (shift_edge) begin
              miso_q <= tx_sh[7];
              tx_sh  <= {tx_sh[6:0], 1'b0};
            end
            if (sample_edge) begin
              rx_sh   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (!rw) regs[addr] <= rx_byte;
                frame_done <= 1'b1;
                byte_seen  <= 1'b1;
`ifdef SPI_SLV_AUTOINC_EN
                addr  <= addr_nxt;
                tx_sh <= rw ? regs[addr_nxt] : 8'h00;
`else
                state <= TAIL;
`endif
              end
            end
          end
          default: miso_q <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_regs.sv
// tb/tb_spi_slave_regs.sv - bit-banged SPI master with a scoreboard of expected register and MISO bytes.
`timescale 1ns/1ps
module tb_spi_slave_regs;

  localparam int HALF = 80;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclk, cs_bar, MOSI;
  logic [1:0] MODE;
  logic [2:0] host_addr;
  logic       MISO, miso_oe;
  logic [7:0] host_rdata;
  logic       frame_done, frame_err;

  spi_slave_regs dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_bar(cs_bar), .MOSI(MOSI),
    .MISO(MISO), .miso_oe(miso_oe), .MODE(MODE), .host_addr(host_addr),
    .host_rdata(host_rdata), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_entry_t;

  sb_entry_t sb[$];
  int n_vec = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int oe_viol = 0;

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    sb_entry_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    sb_entry_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check(e.tag, got, e.val);
    end
  endtask

  task automatic host_read(input logic [2:0] a);
    @(negedge clk);
    host_addr = a;
    #1;
    sb_pop({24'h0, host_rdata});
  endtask

  // MODE is flipped once the frame is under way so a slave that fails to latch it misbehaves.
  task automatic spi_frame(input logic [1:0] m, input logic [23:0] tx, input int nbits,
                           input bit keep_cs, output logic [23:0] rx);
    rx = 24'h0;
    @(negedge clk);
    MODE = m;
    sclk = m[1];
    #(HALF);
    cs_bar = 1'b0;
    #(HALF);
    MODE = ~m;
    for (int i = 0; i < nbits; i++) begin
      if (!m[0]) begin
        MOSI = tx[23-i];
        #(HALF);
        sclk = ~m[1];
        rx = {rx[22:0], MISO};
        if (miso_oe !== 1'b1) oe_viol++;
        #(HALF);
        sclk = m[1];
      end else begin
        sclk = ~m[1];
        MOSI = tx[23-i];
        #(HALF);
        sclk = m[1];
        rx = {rx[22:0], MISO};
        if (miso_oe !== 1'b1) oe_viol++;
        #(HALF);
      end
    end
    MODE = m;
    if (!keep_cs) begin
      #(HALF);
      cs_bar = 1'b1;
      #(4*HALF);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] rx;
    logic [1:0]  modes [2];
    int d0, e0, viol;

    reset = 1'b1; sclk = 1'b0; cs_bar = 1'b1; MOSI = 1'b0; MODE = 2'd0; host_addr = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_miso", {31'h0, MISO}, 32'd0);
    check("rst_oe", {31'h0, miso_oe}, 32'd0);
    check("rst_done", {31'h0, frame_done}, 32'd0);
    check("rst_err", {31'h0, frame_err}, 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      sb_push("rst_reg", 32'h00);
      host_read(a[2:0]);
    end

    // mode 0 write, then mode 0 read-back
    d0 = done_cnt; e0 = err_cnt;
    sb_push("t1_reg3", 32'hA5);
    spi_frame(2'd0, {8'h03, 8'hA5, 8'h00}, 16, 1'b0, rx);
    host_read(3'd3);
    check("t1_done", done_cnt - d0, 32'd1);
    check("t1_err", err_cnt - e0, 32'd0);
    sb_push("t1_miso_rd", 32'hA5);
    spi_frame(2'd0, {8'h83, 8'h00, 8'h00}, 16, 1'b0, rx);
    sb_pop({24'h0, rx[7:0]});

    // mode 3 read
    spi_frame(2'd3, {8'h05, 8'h3C, 8'h00}, 16, 1'b0, rx);
    oe_viol = 0;
    sb_push("t2_miso_cmd", 32'h00);
    sb_push("t2_miso_data", 32'h3C);
    spi_frame(2'd3, {8'h85, 8'h00, 8'h00}, 16, 1'b0, rx);
    sb_pop({24'h0, rx[15:8]});
    sb_pop({24'h0, rx[7:0]});
    check("t2_oe_viol", oe_viol, 32'd0);

    // modes 1 and 2: clear reg1 in mode 0, write 5A, read it back
    modes[0] = 2'd1;
    modes[1] = 2'd2;
    for (int k = 0; k < 2; k++) begin
      spi_frame(2'd0, {8'h01, 8'h00, 8'h00}, 16, 1'b0, rx);
      spi_frame(modes[k], {8'h01, 8'h5A, 8'h00}, 16, 1'b0, rx);
      sb_push("t3_miso_data", 32'h5A);
      sb_push("t3_reg1", 32'h5A);
      spi_frame(modes[k], {8'h81, 8'h00, 8'h00}, 16, 1'b0, rx);
      sb_pop({24'h0, rx[7:0]});
      host_read(3'd1);
    end

    // aborted write after 12 bits
    d0 = done_cnt; e0 = err_cnt;
    sb_push("t4_reg2", 32'h00);
    spi_frame(2'd0, {8'h02, 8'hFF, 8'h00}, 12, 1'b0, rx);
    host_read(3'd2);
    check("t4_err", err_cnt - e0, 32'd1);
    check("t4_done", done_cnt - d0, 32'd0);

    // reset mid-frame with cs_bar held low
    d0 = done_cnt; e0 = err_cnt;
    spi_frame(2'd0, {8'h04, 8'hFF, 8'h00}, 10, 1'b1, rx);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    viol = 0;
    repeat (16) begin
      @(negedge clk);
      if (MISO !== 1'b0 || miso_oe !== 1'b0) viol++;
    end
    check("t5_lockout", viol, 32'd0);
    check("t5_done", done_cnt - d0, 32'd0);
    check("t5_err", err_cnt - e0, 32'd0);
    sb_push("t5_reg4", 32'h00);
    host_read(3'd4);
    cs_bar = 1'b1;
    repeat (8) @(negedge clk);
    sb_push("t5_reg4_after", 32'hC3);
    spi_frame(2'd0, {8'h04, 8'hC3, 8'h00}, 16, 1'b0, rx);
    host_read(3'd4);

    // three-byte frame: second data byte only lands with auto-increment
    d0 = done_cnt; e0 = err_cnt;
    sb_push("t6_reg7", 32'h11);
`ifdef SPI_SLV_AUTOINC_EN
    sb_push("t6_reg0", 32'h22);
`else
    sb_push("t6_reg0", 32'h00);
`endif
    spi_frame(2'd0, {8'h07, 8'h11, 8'h22}, 24, 1'b0, rx);
    host_read(3'd7);
    host_read(3'd0);
`ifdef SPI_SLV_AUTOINC_EN
    check("t6_done", done_cnt - d0, 32'd2);
`else
    check("t6_done", done_cnt - d0, 32'd1);
`endif
    check("t6_err", err_cnt - e0, 32'd0);
    check("sb_left", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_regs.md
SPI_SLAVE_REGS -- requirements
Module: spi_slave_regs

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  system clock; reset  in  1  async active-high reset.
REQ-002 SHALL provide: sclk  in  1  SPI serial clock from master, asynchronous to clk.
REQ-003 SHALL provide: cs_bar  in  1  active-low chip select.
REQ-004 SHALL provide: MOSI  in  1  serial data from master.
REQ-005 SHALL provide: MISO  out  1  serial data to master.
REQ-006 SHALL provide: miso_oe  out  1  high while selected; the top-level mux/tri-state uses it.
REQ-007 SHALL provide: MODE  in  2  SPI mode {CPOL,CPHA}.
REQ-008 SHALL provide: host_addr  in  3  local register read address.
REQ-009 SHALL provide: host_rdata  out  8  combinational read of reg[host_addr].
REQ-010 SHALL provide: frame_done  out  1  one-clk pulse on a complete frame.
REQ-011 SHALL provide: frame_err  out  1  one-clk pulse on an aborted frame.

Function
REQ-012 SHALL pass sclk, cs_bar and MOSI through 2-flop synchronizers and detect sclk edges from the synchronized value; clk >= 8x sclk.
REQ-013 SHALL act on each pin edge within 3 clk cycles (2 sync + 1 edge detect).
REQ-014 SHALL latch MODE on the synchronized cs_bar falling edge and ignore MODE changes mid-frame.
REQ-015 SHALL use this edge mapping: sample edge = leading edge if CPHA=0, trailing edge if CPHA=1; leading = rising if CPOL=0, falling if CPOL=1; shift edge = the other edge.
REQ-016 SHALL transfer MSB first, with frame = command byte then data byte.
REQ-017 SHALL decode the command byte as: bit7 = RW (1 read, 0 write); bits[2:0] = address; bits[6:3] ignored.
REQ-018 SHALL use FSM states IDLE, CMD, DATA, TAIL.
REQ-019 SHALL transition IDLE->CMD on cs_bar fall.
REQ-020 SHALL transition CMD->DATA after the 8th sample edge.
REQ-021 SHALL transition DATA->TAIL after the 16th sample edge.
REQ-022 SHALL return to IDLE from any state on cs_bar rise.
REQ-023 SHALL, in CMD, drive MISO=0.
REQ-024 SHALL, on a read, load reg[addr] into the TX shifter after the 8th sample edge, present bit7 on the next shift edge, and present the following bits on successive shift edges.
REQ-025 SHALL, on a write, commit the received byte to reg[addr] in the clk cycle the 16th sample edge is detected.
REQ-026 SHALL pulse frame_done in the same cycle as that 16th sample edge, for both reads and writes.
REQ-027 SHALL, in TAIL, ignore further bits and drive MISO=0 (unless SPI_SLV_AUTOINC_EN).
REQ-028 SHALL, on cs_bar rise before the 16th sample edge, pulse frame_err, perform no write and return to IDLE.
REQ-029 SHALL NOT pulse frame_err on cs_bar rise in IDLE or TAIL.
REQ-030 SHALL drive miso_oe=1 while synchronized cs_bar is low and not in IDLE-after-reset lockout, else 0.
REQ-031 SHALL drive MISO=0 whenever miso_oe=0.
REQ-032 SHALL make a register written by SPI visible on host_rdata the cycle after commit.

Reset
REQ-033 SHALL, on reset, set: FSM=IDLE, reg[0..7]=8'h00, MISO=0, miso_oe=0, frame_done=0, frame_err=0, bit counter=0, synchronizers to sclk=0, cs_bar=1, MOSI=0.
REQ-034 SHALL, on reset asserted mid-frame, abort the frame immediately with no write and no pulse.
REQ-035 SHALL, after reset release with cs_bar low, stay in IDLE (lockout) until cs_bar is seen high, so no partial frame is accepted.

Configuration
REQ-036 SHALL, with SPI_SLV_AUTOINC_EN defined, continue in DATA after each data byte with addr=addr+1 mod 8 (7 wraps to 0), writing or reading one register per further byte, and pulse frame_done on every completed byte.
REQ-037 SHALL, with SPI_SLV_AUTOINC_EN undefined, behave per REQ-027: one register per frame.

Verification
REQ-038 SHALL test: mode 0, write cmd 8'h03 data 8'hA5 -> reg[3]=A5, host_addr=3 gives A5, one frame_done pulse, no frame_err.
REQ-039 SHALL test: mode 3, reg[5]=3C, read cmd 8'h85 -> MISO bits 0x00 then 0x3C, miso_oe high throughout frame.
REQ-040 SHALL test: modes 1 and 2, write 8'h01/8'h5A then read 8'h81 -> MISO second byte 5A in each mode.
REQ-041 SHALL test: write cmd 8'h02, cs_bar high after 12 bits -> frame_err pulse, reg[2] unchanged 00, no frame_done.
REQ-042 SHALL test: reset pulse after 10 bits of a write with cs_bar held low, then 16 more clocks -> no write, MISO=0, miso_oe=0 until a new cs_bar fall.
REQ-043 SHALL test, with SPI_SLV_AUTOINC_EN: cmd 8'h07 then bytes 11,22 -> reg[7]=11, reg[0]=22, two frame_done pulses; without it -> reg[0] unchanged.
